// File: rtl/camellia_pkg.sv
// Shared definitions for the Camellia F-function: byte-lane positions, FSM
// encoding and the P-function byte mixing.
package camellia_pkg;

  localparam int T1_LSB = 56;
  localparam int T2_LSB = 48;
  localparam int T3_LSB = 40;
  localparam int T4_LSB = 32;
  localparam int T5_LSB = 24;
  localparam int T6_LSB = 16;
  localparam int T7_LSB = 8;
  localparam int T8_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PERM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [63:0] p_func(input logic [63:0] y);
    logic [7:0] y1, y2, y3, y4, y5, y6, y7, y8;
    logic [7:0] z1, z2, z3, z4, z5, z6, z7, z8;
    y1 = y[T1_LSB +: 8];
    y2 = y[T2_LSB +: 8];
    y3 = y[T3_LSB +: 8];
    y4 = y[T4_LSB +: 8];
    y5 = y[T5_LSB +: 8];
    y6 = y[T6_LSB +: 8];
    y7 = y[T7_LSB +: 8];
    y8 = y[T8_LSB +: 8];
    z1 = y1 ^ y3 ^ y4 ^ y6 ^ y7 ^ y8;
    z2 = y1 ^ y2 ^ y4 ^ y5 ^ y7 ^ y8;
    z3 = y1 ^ y2 ^ y3 ^ y5 ^ y6 ^ y8;
    z4 = y2 ^ y3 ^ y4 ^ y5 ^ y6 ^ y7;
    z5 = y1 ^ y2 ^ y6 ^ y7 ^ y8;
    z6 = y2 ^ y3 ^ y5 ^ y7 ^ y8;
    z7 = y3 ^ y4 ^ y5 ^ y6 ^ y8;
    z8 = y1 ^ y4 ^ y5 ^ y6 ^ y7;
    return {z1, z2, z3, z4, z5, z6, z7, z8};
  endfunction

endpackage

// File: rtl/camellia_f_func_p_layer.sv
// Combinational P-layer; also instantiated by the key-schedule F blocks.
module camellia_p_layer
  import camellia_pkg::*;
(
  input  logic [63:0] y_i,
  output logic [63:0] z_o
);

  assign z_o = p_func(y_i);

endmodule

// File: rtl/camellia_f_func.sv
// Camellia F-function requester: drives X^K onto the external S-box ROMs,
// waits out their read latency, then applies the P-layer to the returned bytes.
module camellia_f_func
  import camellia_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x_in,
  input  logic [63:0] k_in,
  output logic [63:0] sbox_addr,
  input  logic [63:0] sbox_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y_out,
  output state_t      dbg_state
);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid holds until out_ready.
  localparam int CW = (ROM_LATENCY < 1) ? 1 : $clog2(ROM_LATENCY + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   s_q, s_d;
  logic [63:0]   y_q, y_d;
  logic          valid_q, valid_d;
  logic [63:0]   p_out;

  camellia_p_layer u_p_layer (
    .y_i (s_q),
    .z_o (p_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      s_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      s_q     <= s_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    s_d     = s_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d  = x_in ^ k_in;
          cnt_d   = CW'(ROM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Address is held stable here; capture once the ROM data has settled.
        if (cnt_q == '0) begin
          s_d     = sbox_dout;
          state_d = PERM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PERM: begin
        y_d     = p_out;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign sbox_addr = addr_q;
  assign out_valid = valid_q;
  assign y_out     = y_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_camellia_f_func.sv
// Directed bench for camellia_f_func with behavioural S-box ROM stubs
// (latency 1 and latency 3 instances).
module tb_camellia_f_func;
  import camellia_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT, ROM_LATENCY = 1 ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] x_in, k_in, sbox_addr, sbox_dout, y_out;
  state_t      dbg_state;
  logic        zmode;

  camellia_f_func #(.ROM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .k_in(k_in), .sbox_addr(sbox_addr), .sbox_dout(sbox_dout),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT, ROM_LATENCY = 3 ----------------
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [63:0] x_in3, k_in3, sbox_addr3, sbox_dout3, y_out3;
  logic [63:0] rom3_a, rom3_b;
  state_t      dbg_state3;

  camellia_f_func #(.ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .x_in(x_in3), .k_in(k_in3), .sbox_addr(sbox_addr3), .sbox_dout(sbox_dout3),
    .out_valid(out_valid3), .out_ready(out_ready3), .y_out(y_out3),
    .dbg_state(dbg_state3)
  );

  // ROM stub: identity, or with zmode the real S-box outputs for address 0
  // (SBOX_1..4(0) = 70,E0,38,70 in lane order y1..y8).
  function automatic logic [63:0] rom_fn(input logic [63:0] a, input logic zm);
    logic [63:0] tab;
    logic [63:0] r;
    tab = 64'h70E03870E0387070;
    r = a;
    for (int i = 0; i < 8; i++)
      if (zm && a[i*8 +: 8] == 8'h00) r[i*8 +: 8] = tab[i*8 +: 8];
    return r;
  endfunction

  initial begin
    sbox_dout  = '0;
    sbox_dout3 = '0;
    rom3_a     = '0;
    rom3_b     = '0;
  end

  always_ff @(posedge clk) begin
    sbox_dout  <= rom_fn(sbox_addr, zmode);
    rom3_a     <= rom_fn(sbox_addr3, 1'b0);
    rom3_b     <= rom3_a;
    sbox_dout3 <= rom3_b;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Launch one operand on the latency-1 DUT and check address, latency, result.
  task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] k,
                        input logic m);
    int n;
    logic [63:0] exp_y;
    exp_y = exp_q.pop_front();
    zmode = m;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check_int({tag, "_in_ready"}, int'(in_ready), 1);
    x_in = x; k_in = k; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check64({tag, "_addr"}, sbox_addr, x ^ k);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check_int({tag, "_latency"}, n, 3);
    check64({tag, "_y"}, y_out, exp_y);
    if (out_ready) begin
      step();
      check_int({tag, "_one_cycle"}, int'(out_valid), 0);
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] x;
    logic [63:0] k;
    logic        zm;
    logic [63:0] y;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    int seen;
    logic [63:0] held_y;
    logic [63:0] held_a;

    vecs[0] = '{"zero_sbox", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b1, 64'h00000000A838E0A8};
    vecs[1] = '{"lane_t1",   64'h0100000000000000, 64'h0,                1'b0, 64'h0101010001000001};
    vecs[2] = '{"lane_t8",   64'h0000000000000001, 64'h0,                1'b0, 64'h0101010001010100};
    vecs[3] = '{"lane_t3",   64'h0,                64'h0000010000000000, 1'b0, 64'h0100010100010100};
    vecs[4] = '{"lane_t4",   64'h0000000100000000, 64'h0,                1'b0, 64'h0101000100000101};
    vecs[5] = '{"all_ff",    64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b0, 64'h00000000FFFFFFFF};
    vecs[6] = '{"x_eq_k",    64'h0011223344556677, 64'h0011223344556677, 1'b0, 64'h0};

    in_valid = 1'b0; x_in = '0; k_in = '0; out_ready = 1'b1; zmode = 1'b0;
    in_valid3 = 1'b0; x_in3 = '0; k_in3 = '0; out_ready3 = 1'b1;

    // reset state
    repeat (2) step();
    check_int("rst_in_ready", int'(in_ready), 1);
    check_int("rst_out_valid", int'(out_valid), 0);
    check64("rst_y", y_out, 64'h0);
    check64("rst_addr", sbox_addr, 64'h0);
    check_int("rst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    step();

    // table-driven vectors, out_ready held high
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].y);
      run_op(vecs[i].name, vecs[i].x, vecs[i].k, vecs[i].zm);
    end

    // ROM_LATENCY = 3: five-cycle latency, address held throughout
    x_in3 = 64'h0100000000000000; k_in3 = 64'h0; in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    check64("lat3_addr", sbox_addr3, 64'h0100000000000000);
    n = 0; seen = 0;
    while (!out_valid3 && n < 30) begin
      step(); n++;
      if (sbox_addr3 !== 64'h0100000000000000) seen++;
    end
    check_int("lat3_latency", n, 5);
    check_int("lat3_addr_stable", seen, 0);
    check64("lat3_y", y_out3, 64'h0101010001000001);

    // backpressure: result held, second operand refused
    out_ready = 1'b0;
    exp_q.push_back(64'h0101010001000001);
    run_op("bp", 64'h0100000000000000, 64'h0, 1'b0);
    held_y = y_out;
    held_a = sbox_addr;
    x_in = 64'hFFFFFFFFFFFFFFFF; k_in = 64'h0; in_valid = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || y_out !== held_y || sbox_addr !== held_a)
        seen++;
    end
    check_int("bp_hold", seen, 0);
    check64("bp_y_held", y_out, 64'h0101010001000001);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_int("bp_release_valid", int'(out_valid), 0);
    check_int("bp_release_ready", int'(in_ready), 1);
    check64("bp_not_accepted", sbox_addr, 64'h0100000000000000);

    // reset during WAIT discards the operand
    x_in = 64'h0000000000000001; k_in = 64'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_int("abort_in_wait", int'(dbg_state), int'(WAIT));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_int("abort_in_ready", int'(in_ready), 1);
    check_int("abort_out_valid", int'(out_valid), 0);
    check64("abort_y", y_out, 64'h0);
    check64("abort_addr", sbox_addr, 64'h0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen++;
    end
    check_int("abort_no_result", seen, 0);
    exp_q.push_back(64'h0100010100010100);
    run_op("after_abort", 64'h0, 64'h0000010000000000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
